// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle RV32I controller.
// EXECJALR/EXECLUI states exist only when MC_EXT_OPS_EN is defined.
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL
`ifdef MC_EXT_OPS_EN
        , EXECJALR, EXECLUI
`endif
    } state_t;

    localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10, SRCA_ZERO = 2'b11;
    localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011, ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus funct fields to the ALU operation code.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);
    // sub only for R-type (op5 set); addi with funct7b5 set stays an add
    always_comb begin
        alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                      alu_op == ALUOP_SUB ? ALU_SUB :
                      funct3 == 3'b000    ? (funct7b5 & op5 ? ALU_SUB : ALU_ADD) :
                      funct3 == 3'b010    ? ALU_SLT :
                      funct3 == 3'b110    ? ALU_OR :
                      funct3 == 3'b111    ? ALU_AND : ALU_ADD;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore sequencing FSM for the multicycle RV32I core.
// Define MC_EXT_OPS_EN to support jalr and lui; otherwise they retire as no-ops.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc
);
    state_t state, state_next;
    logic [1:0] alu_op;
    logic pc_update, branch, mem_write, ir_write, reg_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE:
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
`ifdef MC_EXT_OPS_EN
                    OP_JALR:      state_next = EXECJALR;
                    OP_LUI:       state_next = EXECLUI;
`endif
                    default:      state_next = FETCH;
                endcase
            MEMADR:   state_next = op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            JAL:      state_next = ALUWB;
`ifdef MC_EXT_OPS_EN
            EXECJALR: state_next = JAL;
            EXECLUI:  state_next = ALUWB;
`endif
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        {AdrSrc, mem_write, ir_write, reg_write, pc_update, branch} = 6'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA = SRCA_PC;
        ALUSrcB = SRCB_RD2;
        alu_op = ALUOP_ADD;
        case (state)
            FETCH: begin
                ir_write = 1'b1;
                pc_update = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            MEMWRITE: {AdrSrc, mem_write} = 2'b11;
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                alu_op = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op = ALUOP_FUNCT;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                ALUSrcA = SRCA_RD1;
                alu_op = ALUOP_SUB;
                branch = 1'b1;
            end
            JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pc_update = 1'b1;
            end
`ifdef MC_EXT_OPS_EN
            EXECJALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            EXECLUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
`endif
            default: ;
        endcase
    end

    // reset parks the FSM in FETCH, so the write strobes must be suppressed here
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign MemWrite = ~reset & mem_write;
    assign IRWrite  = ~reset & ir_write;
    assign RegWrite = ~reset & reg_write;

    always_comb begin
        ImmSrc = op == OP_SW  ? IMM_S :
                 op == OP_BEQ ? IMM_B :
                 op == OP_JAL ? IMM_J :
`ifdef MC_EXT_OPS_EN
                 op == OP_LUI ? IMM_U :
`endif
                 IMM_I;
    end

    alu_decoder u_alu_decoder (
        .alu_op(alu_op),
        .funct3(funct3),
        .funct7b5(funct7b5),
        .op5(op[5]),
        .alu_control(ALUControl)
    );
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing controller for the multicycle RV32I core. Decodes the latched instruction fields and walks a Moore state machine. Each cycle it drives the enables and mux selects that time-share the single ALU, the unified instruction/data memory and the register file. It replaces the single-cycle control path and sits between the instruction register and the multicycle datapath.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  7  Instr[6:0] from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register (and OldPC) enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U

## Operation
- Internal ALUOp: 00 add, 01 sub, 10 funct-decoded.
- ALU decode for ALUOp = 10, by funct3:
  - 000: sub if funct7b5 & op[5], else add.
  - 010: slt; 110: or; 111: and.
  - Any other funct3: add.
- ImmSrc is decoded combinationally from op, independent of state. Unknown op gives 000.
- PCWrite = PCUpdate | (Branch & Zero).
- States and asserted outputs; any output not listed is 0 / 00 / 000:
  - FETCH: AdrSrc 0, IRWrite, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate. Next: DECODE.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (computes branch/jump target).
  - DECODE next state by op:
    - lw/sw → MEMADR
    - R-type → EXECR
    - I-ALU → EXECI
    - beq → BEQ
    - jal → JAL
    - jalr → EXECJALR
    - lui → EXECLUI
    - any other op → FETCH
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: ResultSrc 00, AdrSrc 1. Next: MEMWB.
  - MEMWB: ResultSrc 01, RegWrite. Next: FETCH.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite. Next: FETCH.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10. Next: ALUWB.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp 10. Next: ALUWB.
  - ALUWB: ResultSrc 00, RegWrite. Next: FETCH.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch. Next: FETCH.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate. Next: ALUWB (writes OldPC+4).
  - EXECJALR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Next: JAL.
  - EXECLUI: ALUSrcA 11, ALUSrcB 01, ALUOp 00. Next: ALUWB.
- jalr target LSB masking is a datapath responsibility, not this block's.
- An unrecognised op in DECODE retires as a no-op: no register, memory or PC write beyond the FETCH increment.

## Timing
- All outputs are Moore decode of the state register. The exceptions are the Zero term in PCWrite and the op/funct terms in ALUControl and ImmSrc, which are combinational.
- Cycles per instruction:
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - beq 3
  - jal 4
  - jalr 5
  - lui 4
  - illegal 2
- reset asserted: state goes to FETCH immediately and asynchronously, mid-instruction included.
  - While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - All other outputs take their FETCH values: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ResultSrc 10, ALUControl 000, ImmSrc per op.
- First rising edge after reset deasserts: a full FETCH is performed.
- Zero is sampled only in BEQ. Changes on Zero in any other state have no effect.

## Configuration
- MC_EXT_OPS_EN defined: jalr (1100111) and lui (0110111) are supported via EXECJALR and EXECLUI.
- MC_EXT_OPS_EN undefined: those states are not compiled. Both opcodes take the illegal path (DECODE → FETCH, 2 cycles), and ImmSrc never produces 100.

## Structure
- Package mc_pkg holds:
  - state enum
  - ALUOp, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
  - opcode constants
  - ALUControl codes
- Sub-module alu_decoder (ALUOp, funct3, funct7b5, op[5] → ALUControl). It is combinational and instantiated once.
- The FSM, the output decode and the ImmSrc decode live in multicycle_controller.

## Test plan
- add (op 0110011, funct3 000, funct7b5 0) → FETCH, DECODE, EXECR, ALUWB. ALUControl 000 in EXECR; RegWrite 1 only in cycle 4; back in FETCH at cycle 5.
- sub (funct7b5 1) → ALUControl 001 in EXECR. addi with funct7b5 1 → ALUControl 000.
- lw → 5 cycles, MemWrite 0 throughout, ResultSrc 01 with RegWrite 1 in MEMWB. sw → MemWrite 1 in cycle 4 only, RegWrite 0 throughout.
- beq, Zero 0 → PCWrite 0 in BEQ. beq, Zero 1 → PCWrite 1 in BEQ. Zero toggling in DECODE has no effect.
- jalr and lui with MC_EXT_OPS_EN defined → 5 cycles and 4 cycles. jalr ends with PCWrite 1 in JAL then RegWrite 1; lui ends with ImmSrc 100, ALUSrcA 11. Without the macro, both take 2 cycles and RegWrite stays 0.
- reset pulsed mid-MEMREAD of lw → outputs switch to FETCH values immediately with all write enables 0. The next instruction starts cleanly at FETCH and no MEMWB occurs.
